quad_decoder_updn: RTL and testbench

QUAD_DECODER_UPDN -- requirements
Module: quad_decoder_updn

---
 rtl/quad_decoder_updn_if.sv | 15 +
 rtl/quad_decoder_updn.sv | 144 ++++++++++++++
 tb/tb_quad_decoder_updn.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_updn_if.sv
// Encoder inputs and count-pulse outputs of quad_decoder_updn.
// master = the side driving the encoder lines; slave = the decoder.
interface quad_decoder_updn_if;
   logic       a_in;
   logic       b_in;
   logic [1:0] mode;
   logic       clr_err;
   logic       eup;
   logic       edn;
   logic       dir;
   logic       err;

   modport master (output a_in, b_in, mode, clr_err, input eup, edn, dir, err);
   modport slave  (input a_in, b_in, mode, clr_err, output eup, edn, dir, err);
endinterface

// File: rtl/quad_decoder_updn.sv
// Quadrature decoder: synchronizes and glitch-filters A/B, then emits
// registered up/down count pulses at x4/x2/x1 resolution, with a sticky error flag.

module qd_chan_filt #(
   parameter int FILT_LEN = 4,
   parameter int FILT_W   = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic load,
   output logic synced,
   output logic filt
);
   localparam logic [FILT_W-1:0] CNT_TOP = FILT_W'(FILT_LEN - 1);

   logic [1:0]        sync;
   logic [FILT_W-1:0] cnt;

   assign synced = sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
         cnt  <= '0;
         filt <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         // During the init window the filter simply tracks the synchronizer.
         if (load) begin
            filt <= sync[1];
            cnt  <= '0;
         end else if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_TOP) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + FILT_W'(1);
         end
      end
   end
endmodule

module quad_decoder_updn #(
   parameter int FILT_LEN = 4,
   parameter int FILT_W   = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   quad_decoder_updn_if.slave  bus
);
   localparam int NUM_CH = 2;
   localparam int INIT_W = FILT_W + 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILT_LEN + 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state, state_nxt;
   logic [INIT_W-1:0]   init_cnt, init_cnt_nxt;
   logic                load;

   // Bit 1 is channel A, bit 0 is channel B.
   logic [NUM_CH-1:0]   raw, synced, filt, prev;
   logic                a_chg, b_chg, fwd, hit, illegal, up_nxt, dn_nxt;
   logic                eup, edn, dir, err;

   assign raw = {bus.a_in, bus.b_in};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      qd_chan_filt #(.FILT_LEN(FILT_LEN), .FILT_W(FILT_W)) u_filt (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (raw[ch]),
         .load    (load),
         .synced  (synced[ch]),
         .filt    (filt[ch])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      load         = 1'b0;
      case (state)
         S_INIT: begin
            load = 1'b1;
            if (init_cnt == INIT_LAST) state_nxt = S_RUN;
            else                       init_cnt_nxt = init_cnt + INIT_W'(1);
         end
         default: ;
      endcase
   end

   assign a_chg   = filt[1] ^ prev[1];
   assign b_chg   = filt[0] ^ prev[0];
   assign illegal = a_chg & b_chg & ~load;
   // Gray-code step direction: forward iff old A equals new B.
   assign fwd     = ~(prev[1] ^ filt[0]);

   always_comb begin
      hit = 1'b0;
      case (bus.mode)
         2'b01:   hit = a_chg & ~b_chg;
         2'b10:   hit = a_chg & ~b_chg & filt[1];
         default: hit = a_chg ^ b_chg;
      endcase
   end

   assign up_nxt = hit & fwd  & ~load;
   assign dn_nxt = hit & ~fwd & ~load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= '0;
         eup  <= 1'b0;
         edn  <= 1'b0;
         dir  <= 1'b0;
         err  <= 1'b0;
      end else begin
         prev <= load ? synced : filt;
         eup  <= up_nxt;
         edn  <= dn_nxt;
         if (up_nxt | dn_nxt) dir <= up_nxt;
         if (illegal)          err <= 1'b1;
         else if (bus.clr_err) err <= 1'b0;
      end
   end

   assign bus.eup = eup;
   assign bus.edn = edn;
   assign bus.dir = dir;
   assign bus.err = err;
endmodule

// File: tb/tb_quad_decoder_updn.sv
// Directed + randomized bench for quad_decoder_updn against a positional
// (Gray-index) reference model of sync delay, run-length filter and decoder.
module tb_quad_decoder_updn;
   localparam int FILT_LEN = 4;
   localparam int FILT_W   = 3;

   logic clk = 1'b0;
   logic reset_n;
   quad_decoder_updn_if bus ();

   quad_decoder_updn #(.FILT_LEN(FILT_LEN), .FILT_W(FILT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_up, n_dn, ncyc, t0, first_pulse;

   // Reference model state
   logic [1:0] m_hist [2] = '{2'b00, 2'b00};
   int         m_run [2]  = '{0, 0};
   logic [1:0] m_filt = 2'b00, m_ref = 2'b00, m_dly;
   logic       m_up = 1'b0, m_dn = 1'b0, m_dir = 1'b0, m_err = 1'b0;
   int         m_edges = 0, m_d;
   logic       m_hit, m_init, m_ill;

   function automatic int pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hist[0] = 2'b00; m_hist[1] = 2'b00;
         m_run[0] = 0; m_run[1] = 0;
         m_filt = 2'b00; m_ref = 2'b00;
         m_up = 1'b0; m_dn = 1'b0; m_dir = 1'b0; m_err = 1'b0;
         m_edges = 0;
      end else begin
         m_dly  = m_hist[1];
         m_init = (m_edges < FILT_LEN + 2);
         m_up = 1'b0; m_dn = 1'b0; m_ill = 1'b0;
         if (m_init) begin
            m_filt = m_dly; m_ref = m_dly;
            m_run[0] = 0; m_run[1] = 0;
         end else begin
            m_d = (pos(m_filt) - pos(m_ref)) & 3;
            case (bus.mode)
               2'b01:   m_hit = (m_filt[1] != m_ref[1]);
               2'b10:   m_hit = (m_filt[1] != m_ref[1]) && m_filt[1];
               default: m_hit = 1'b1;
            endcase
            if (m_d == 2) m_ill = 1'b1;
            else if (m_d != 0 && m_hit) begin
               m_up = (m_d == 1); m_dn = (m_d == 3); m_dir = (m_d == 1);
            end
            m_ref = m_filt;
            for (int c = 0; c < 2; c++) begin
               if (m_dly[c] != m_filt[c]) begin
                  m_run[c]++;
                  if (m_run[c] == FILT_LEN) begin m_filt[c] = m_dly[c]; m_run[c] = 0; end
               end else m_run[c] = 0;
            end
         end
         if (m_ill) m_err = 1'b1;
         else if (bus.clr_err) m_err = 1'b0;
         m_hist[1] = m_hist[0];
         m_hist[0] = {bus.a_in, bus.b_in};
         if (m_edges < 1000000) m_edges++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ncyc++;
         if (bus.eup === 1'b1) n_up++;
         if (bus.edn === 1'b1) n_dn++;
         if ((bus.eup === 1'b1 || bus.edn === 1'b1) && first_pulse < 0) first_pulse = ncyc - t0;
         chk("eup", bus.eup, m_up);
         chk("edn", bus.edn, m_dn);
         chk("dir", bus.dir, m_dir);
         chk("err", bus.err, m_err);
         chk("excl", bus.eup & bus.edn, 0);
      end
   endtask

   task automatic step(input logic [1:0] ab, input int hold);
      bus.a_in = ab[1]; bus.b_in = ab[0];
      t0 = ncyc; first_pulse = -1;
      cyc(hold);
   endtask

   task automatic clr_cnt();
      n_up = 0; n_dn = 0;
   endtask

   logic [1:0] cur, msk;
   logic seen;

   initial begin
      ncyc = 0; first_pulse = -1; t0 = 0;
      clr_cnt();
      reset_n = 1'b0;
      bus.a_in = 1'b0; bus.b_in = 1'b0; bus.mode = 2'b00; bus.clr_err = 1'b0;
      cyc(3);
      chk("rst_eup", bus.eup, 0); chk("rst_edn", bus.edn, 0);
      chk("rst_dir", bus.dir, 0); chk("rst_err", bus.err, 0);
      reset_n = 1'b1;
      cyc(10);

      // x4 forward cycle with latency
      clr_cnt();
      step(2'b10, 10); chk("lat_x4", first_pulse, FILT_LEN + 3);
      step(2'b11, 10); chk("lat_x4", first_pulse, FILT_LEN + 3);
      step(2'b01, 10); chk("lat_x4", first_pulse, FILT_LEN + 3);
      step(2'b00, 10); chk("lat_x4", first_pulse, FILT_LEN + 3);
      chk("x4_nup", n_up, 4); chk("x4_ndn", n_dn, 0);
      chk("x4_dir", bus.dir, 1); chk("x4_err", bus.err, 0);

      // x1 reverse, two full cycles
      bus.mode = 2'b10; clr_cnt();
      for (int k = 0; k < 2; k++) begin
         step(2'b01, 10); step(2'b11, 10); step(2'b10, 10); step(2'b00, 10);
      end
      chk("x1_ndn", n_dn, 2); chk("x1_nup", n_up, 0); chk("x1_dir", bus.dir, 0);

      // glitch filter
      bus.mode = 2'b00; clr_cnt();
      step(2'b10, 3); step(2'b00, 12);
      chk("glitch_nup", n_up, 0); chk("glitch_ndn", n_dn, 0);
      step(2'b10, 6); step(2'b00, 12);
      chk("hold6_nup", n_up, 1); chk("hold6_ndn", n_dn, 1);

      // illegal transitions and clr_err priority
      clr_cnt();
      step(2'b11, 12);
      chk("ill_err", bus.err, 1); chk("ill_nup", n_up, 0); chk("ill_ndn", n_dn, 0);
      bus.clr_err = 1'b1; cyc(1); bus.clr_err = 1'b0; cyc(2);
      chk("clr_err", bus.err, 0);
      step(2'b00, 6);
      bus.clr_err = 1'b1; cyc(1); bus.clr_err = 1'b0;
      chk("clr_vs_ill", bus.err, 1);
      cyc(6);
      chk("ill2_nup", n_up, 0); chk("ill2_ndn", n_dn, 0);

      // init window with inputs held at 10
      bus.a_in = 1'b1; bus.b_in = 1'b0; reset_n = 1'b0;
      cyc(3);
      reset_n = 1'b1; clr_cnt();
      cyc(15);
      chk("init_nup", n_up, 0); chk("init_ndn", n_dn, 0); chk("init_err", bus.err, 0);
      step(2'b11, 10);
      chk("post_init_nup", n_up, 1); chk("post_init_ndn", n_dn, 0);
      chk("lat_post_init", first_pulse, FILT_LEN + 3);

      // reset while eup is high
      bus.a_in = 1'b0; bus.b_in = 1'b1; t0 = ncyc; first_pulse = -1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cyc(1);
         seen = (bus.eup === 1'b1);
      end
      chk("rst_pulse_seen", seen, 1);
      chk("rst_pre_dir", bus.dir, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_eup", bus.eup, 0); chk("rst_mid_dir", bus.dir, 0); chk("rst_mid_err", bus.err, 0);
      cyc(2);
      reset_n = 1'b1; clr_cnt();
      cyc(20);
      chk("rst_owed_nup", n_up, 0); chk("rst_owed_ndn", n_dn, 0);

      // randomized segments against the model
      cur = {bus.a_in, bus.b_in};
      for (int s = 0; s < 70; s++) begin
         bus.mode = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0, 1:    msk = 2'b10;
            2, 3:    msk = 2'b01;
            4:       msk = 2'b11;
            default: msk = 2'b00;
         endcase
         cur = cur ^ msk;
         bus.clr_err = ($urandom_range(0, 7) == 0);
         step(cur, $urandom_range(1, 12));
      end
      bus.clr_err = 1'b0;
      cyc(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
